// File: rtl/axi_flat_pkg.sv
// Shared AXI encodings, FSM state type and burst legality helper for the flat-AXI blocks.
package axi_flat_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_RESP = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } state_e;

    // A burst we refuse to service: reserved type, oversize beat, or a wrap length AXI forbids.
    function automatic logic burst_illegal(input logic [1:0]  burst,
                                           input logic [7:0]  len,
                                           input logic [2:0]  size,
                                           input int unsigned max_size);
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (burst == 2'b11) || (32'(size) > max_size) ||
               ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP AXI bursts.
module axi_burst_addr_gen
    import axi_flat_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           len_i,
    input  logic [2:0]           size_i,
    input  logic [1:0]           burst_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    logic [AddrWidth-1:0] step;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] incr_addr;

    always_comb begin
        step      = AddrWidth'(1) << size_i;
        // Wrap lengths are powers of two, so the container is a simple aligned mask.
        wrap_mask = ((AddrWidth'(len_i) + AddrWidth'(1)) << size_i) - AddrWidth'(1);
        incr_addr = addr_i + step;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_flat_mem_slv.sv
// AXI4 responder serialising one burst at a time onto a 1-cycle-latency SRAM port.
// Define AXI_FLAT_MEM_SLV_ADDR_CHECK_EN to answer out-of-range beats with DECERR.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | arbitrate AR/AW, latch burst parameters
// ST_RD_REQ  | issue memory read for the current beat
// ST_RD_WAIT | capture memory read data
// ST_RD_RESP | present R beat, hold until rready
// ST_WR_DATA | accept W beats, write memory in the handshake cycle
// ST_WR_RESP | present B response, hold until bready
module axi_flat_mem_slv
    import axi_flat_pkg::*;
#(
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned MemWords  = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic [IdWidth-1:0]           s_axi_arid,
    input  logic [AddrWidth-1:0]         s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,

    output logic [IdWidth-1:0]           s_axi_rid,
    output logic [DataWidth-1:0]         s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,

    input  logic [IdWidth-1:0]           s_axi_awid,
    input  logic [AddrWidth-1:0]         s_axi_awaddr,
    input  logic [7:0]                   s_axi_awlen,
    input  logic [2:0]                   s_axi_awsize,
    input  logic [1:0]                   s_axi_awburst,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,

    input  logic [DataWidth-1:0]         s_axi_wdata,
    input  logic [DataWidth/8-1:0]       s_axi_wstrb,
    input  logic                         s_axi_wlast,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,

    output logic [IdWidth-1:0]           s_axi_bid,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,

    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MemWords)-1:0]  mem_addr_o,
    output logic [DataWidth-1:0]         mem_wdata_o,
    output logic [DataWidth/8-1:0]       mem_be_o,
    input  logic [DataWidth-1:0]         mem_rdata_i
);

    localparam int unsigned ByteAw = $clog2(DataWidth / 8);
    localparam int unsigned MemAw  = $clog2(MemWords);

    state_e               state_q, state_d;
    logic                 prio_rd_q, prio_rd_d;
    logic                 run_q, run_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           beat_q, beat_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic                 err_q, err_d;
    logic                 dec_q, dec_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic [AddrWidth-1:0] next_addr;
    logic                 ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic                 last_beat;
    logic                 oor;
    logic                 idle_live;
    logic                 ar_rdy, aw_rdy;
    logic [1:0]           beat_resp;

    axi_burst_addr_gen #(
        .AddrWidth (AddrWidth)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

`ifdef AXI_FLAT_MEM_SLV_ADDR_CHECK_EN
    assign oor = (addr_q >> ByteAw) >= AddrWidth'(MemWords);
`else
    assign oor = 1'b0;
`endif

    assign last_beat  = (beat_q == len_q);
    assign idle_live  = run_q && (state_q == ST_IDLE);
    assign ar_hs      = s_axi_arvalid && s_axi_arready;
    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign r_hs       = s_axi_rvalid && s_axi_rready;
    assign b_hs       = s_axi_bvalid && s_axi_bready;
    assign mem_addr_o = addr_q[ByteAw +: MemAw];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = ST_RD_REQ;
                end else if (aw_hs) begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_RD_RESP;
            ST_RD_RESP: begin
                if (r_hs) begin
                    state_d = last_beat ? ST_IDLE : ST_RD_REQ;
                end
            end
            ST_WR_DATA: begin
                if (w_hs && last_beat) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst context
    always_comb begin
        run_d     = 1'b1;
        prio_rd_d = prio_rd_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        dec_d     = dec_q;
        rdata_d   = rdata_q;

        if (ar_hs) begin
            prio_rd_d = !prio_rd_q;
            id_d      = s_axi_arid;
            addr_d    = s_axi_araddr;
            len_d     = s_axi_arlen;
            size_d    = s_axi_arsize;
            burst_d   = s_axi_arburst;
            beat_d    = 8'd0;
            err_d     = burst_illegal(s_axi_arburst, s_axi_arlen, s_axi_arsize, ByteAw);
            dec_d     = 1'b0;
        end else if (aw_hs) begin
            prio_rd_d = !prio_rd_q;
            id_d      = s_axi_awid;
            addr_d    = s_axi_awaddr;
            len_d     = s_axi_awlen;
            size_d    = s_axi_awsize;
            burst_d   = s_axi_awburst;
            beat_d    = 8'd0;
            err_d     = burst_illegal(s_axi_awburst, s_axi_awlen, s_axi_awsize, ByteAw);
            dec_d     = 1'b0;
        end

        if (state_q == ST_RD_WAIT) begin
            rdata_d = (err_q || oor) ? '0 : mem_rdata_i;
        end

        if (r_hs && !last_beat) begin
            addr_d = next_addr;
            beat_d = beat_q + 8'd1;
        end

        // The beat count, not wlast, ends the burst; a disagreeing wlast only flags the error.
        if (w_hs) begin
            if (s_axi_wlast != last_beat) begin
                err_d = 1'b1;
            end
            if (oor) begin
                dec_d = 1'b1;
            end
            if (!last_beat) begin
                addr_d = next_addr;
                beat_d = beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q     <= 1'b0;
            prio_rd_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            dec_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            run_q     <= run_d;
            prio_rd_q <= prio_rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            dec_q     <= dec_d;
            rdata_q   <= rdata_d;
        end
    end

    // Output logic
    always_comb begin
        // The favoured side is also ready when neither side requests, so the two readies never coincide.
        if (prio_rd_q) begin
            ar_rdy = s_axi_arvalid || !s_axi_awvalid;
            aw_rdy = s_axi_awvalid && !s_axi_arvalid;
        end else begin
            aw_rdy = s_axi_awvalid || !s_axi_arvalid;
            ar_rdy = s_axi_arvalid && !s_axi_awvalid;
        end
        s_axi_arready = idle_live && ar_rdy;
        s_axi_awready = idle_live && aw_rdy;

        if (oor) begin
            beat_resp = RESP_DECERR;
        end else if (err_q) begin
            beat_resp = RESP_SLVERR;
        end else begin
            beat_resp = RESP_OKAY;
        end

        s_axi_rvalid = (state_q == ST_RD_RESP);
        s_axi_rlast  = s_axi_rvalid && last_beat;
        s_axi_rresp  = s_axi_rvalid ? beat_resp : RESP_OKAY;
        s_axi_rdata  = rdata_q;
        s_axi_rid    = id_q;

        s_axi_wready = (state_q == ST_WR_DATA);

        s_axi_bvalid = (state_q == ST_WR_RESP);
        s_axi_bid    = id_q;
        if (!s_axi_bvalid) begin
            s_axi_bresp = RESP_OKAY;
        end else if (dec_q) begin
            s_axi_bresp = RESP_DECERR;
        end else if (err_q) begin
            s_axi_bresp = RESP_SLVERR;
        end else begin
            s_axi_bresp = RESP_OKAY;
        end

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if ((state_q == ST_RD_REQ) && !err_q && !oor) begin
            mem_req_o = 1'b1;
        end
        if ((state_q == ST_WR_DATA) && s_axi_wvalid && !err_q && !oor) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_wdata_o = s_axi_wdata;
            mem_be_o    = s_axi_wstrb;
        end
    end

endmodule
